hazard_detection_unit: RTL and testbench

HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

---
 rtl/hazard_detection_unit_pkg.sv | 10 +
 rtl/hazard_detection_unit_sat_counter.sv | 14 +
 rtl/hazard_detection_unit.sv | 82 ++++++++
 tb/tb_hazard_detection_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_detection_unit_pkg.sv
// hazard_detection_unit_pkg: shared pipeline control state encodings and defaults
package hazard_detection_unit_pkg;
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } hdu_state_t;
  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// sat_counter: saturating event counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
  end
endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: load-use stall, branch flush and HLT drain control
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [3:0]       ID_EX_RegisterRd,
  input  logic [3:0]       IF_ID_RegisterRs,
  input  logic [3:0]       IF_ID_RegisterRt,
  input  logic             IF_ID_UsesRs,
  input  logic             IF_ID_UsesRt,
  input  logic             IF_ID_Hlt,
  input  logic             EX_BranchTaken,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  hdu_state_t state, state_next;
  logic [DW-1:0] cnt, cnt_next;
  logic load_use, stall_inc, flush_inc;
  assign load_use = ID_EX_MemRead && ID_EX_RegisterRd != 4'd0 &&
                    ((IF_ID_UsesRs && ID_EX_RegisterRd == IF_ID_RegisterRs) ||
                     (IF_ID_UsesRt && ID_EX_RegisterRd == IF_ID_RegisterRt));
  assign stall_inc = state == RUN && !EX_BranchTaken && load_use;
  assign flush_inc = state != HALTED && EX_BranchTaken;
  always_comb begin
    state_next = state;
    cnt_next = cnt;
    PC_Write = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Bubble = 1'b0;
    // reset forces the idle-run outputs regardless of the FSM state
    if (rst) begin
    end else if (state == HALTED) begin
      PC_Write = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (EX_BranchTaken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Bubble = 1'b1;
      state_next = RUN;
    end else if (state == DRAIN) begin
      PC_Write = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Bubble = 1'b1;
      state_next = cnt == '0 ? HALTED : DRAIN;
      cnt_next = cnt == '0 ? cnt : cnt - 1'b1;
    end else if (load_use) begin
      PC_Write = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (IF_ID_Hlt) begin
      PC_Write = 1'b0;
      IF_ID_Write = 1'b0;
      cnt_next = DW'(DRAIN_CYCLES - 1);
      state_next = DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      Halted <= 1'b0;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
      Halted <= state_next == HALTED;
    end
  end
  sat_counter #(.W(CNT_W)) u_stall (.clk(clk), .rst(rst), .inc(stall_inc), .count(StallCount));
  sat_counter #(.W(CNT_W)) u_flush (.clk(clk), .rst(rst), .inc(flush_inc), .count(FlushCount));
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: table vectors plus drain, halt and saturation sequences
module tb_hazard_detection_unit;
  logic clk = 1'b0;
  logic rst;
  logic mr, ur, ut, hlt, br;
  logic [3:0] rd, rs, rt;
  logic pc, ifw, fl, bub, halted;
  logic [15:0] sc, fc;
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic mr;
    logic [3:0] rd, rs, rt;
    logic ur, ut, hlt, br;
  } in_t;
  typedef struct {
    in_t i;
    logic pc, ifw, fl, bub, ds, df;
  } vec_t;

  hazard_detection_unit dut (
    .clk(clk), .rst(rst),
    .ID_EX_MemRead(mr), .ID_EX_RegisterRd(rd),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt),
    .IF_ID_UsesRs(ur), .IF_ID_UsesRt(ut),
    .IF_ID_Hlt(hlt), .EX_BranchTaken(br),
    .PC_Write(pc), .IF_ID_Write(ifw), .IF_ID_Flush(fl), .ID_EX_Bubble(bub),
    .Halted(halted), .StallCount(sc), .FlushCount(fc)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic vmr, input logic [3:0] vrd, vrs, vrt,
                              input logic vur, vut, vhlt, vbr,
                              input logic vpc, vifw, vfl, vbub, vds, vdf);
    vec_t v;
    v.i = '{vmr, vrd, vrs, vrt, vur, vut, vhlt, vbr};
    v.pc = vpc; v.ifw = vifw; v.fl = vfl; v.bub = vbub; v.ds = vds; v.df = vdf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t x);
    {mr, rd, rs, rt, ur, ut, hlt, br} = x;
  endtask

  task automatic outs(input string name, input logic epc, eifw, efl, ebub, ehalt);
    chk({name, ".pc"}, {15'd0, pc}, {15'd0, epc});
    chk({name, ".ifw"}, {15'd0, ifw}, {15'd0, eifw});
    chk({name, ".flush"}, {15'd0, fl}, {15'd0, efl});
    chk({name, ".bubble"}, {15'd0, bub}, {15'd0, ebub});
    chk({name, ".halted"}, {15'd0, halted}, {15'd0, ehalt});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  vec_t v[10];
  int es, ef;

  initial begin
    v[0] = mk(1, 3, 3, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0);
    v[1] = mk(1, 0, 0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0);
    v[2] = mk(1, 3, 3, 0, 1, 0, 0, 1,  1, 1, 1, 1, 0, 1);
    v[3] = mk(1, 5, 1, 5, 0, 1, 0, 0,  0, 0, 0, 1, 1, 0);
    v[4] = mk(1, 5, 1, 5, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    v[5] = mk(0, 3, 3, 3, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0);
    v[6] = mk(0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 1, 1, 0, 1);
    v[7] = mk(1, 7, 7, 0, 1, 0, 1, 0,  0, 0, 0, 1, 1, 0);
    v[8] = mk(0, 0, 0, 0, 0, 0, 1, 1,  1, 1, 1, 1, 0, 1);
    v[9] = mk(1, 2, 3, 4, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0);

    // reset held with a live load-use hazard on the inputs
    drive(v[0].i);
    rst = 1'b1;
    tick(); tick();
    outs("rst_held", 1, 1, 0, 0, 0);
    chk("rst.stall", sc, 16'd0);
    chk("rst.flush", fc, 16'd0);
    rst = 1'b0;
    drive('0);
    tick();

    es = 0; ef = 0;
    for (int k = 0; k < 10; k++) begin
      drive(v[k].i);
      #1;
      outs($sformatf("vec%0d", k), v[k].pc, v[k].ifw, v[k].fl, v[k].bub, 0);
      tick();
      es += int'(v[k].ds);
      ef += int'(v[k].df);
      chk($sformatf("vec%0d.stall", k), sc, 16'(es));
      chk($sformatf("vec%0d.flushc", k), fc, 16'(ef));
    end

    // HLT accepted, three drain cycles, then halted until reset
    drive('0);
    do_reset();
    hlt = 1'b1;
    #1;
    outs("hlt_acc", 0, 0, 0, 0, 0);
    tick();
    hlt = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      outs($sformatf("drain%0d", k), 0, 0, 0, 1, 0);
      tick();
    end
    outs("halted4", 0, 0, 0, 1, 1);
    br = 1'b1; mr = 1'b1; rd = 4'd3; rs = 4'd3; ur = 1'b1;
    #1;
    outs("halted_ign", 0, 0, 0, 1, 1);
    tick();
    outs("halted_stay", 0, 0, 0, 1, 1);
    chk("halted.flushc", fc, 16'd0);
    chk("halted.stall", sc, 16'd0);
    drive('0);
    do_reset();
    outs("post_halt_rst", 1, 1, 0, 0, 0);

    // branch on the second drain cycle aborts the halt
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
    tick();
    br = 1'b1;
    #1;
    outs("drain_br", 1, 1, 1, 1, 0);
    tick();
    br = 1'b0;
    #1;
    outs("after_abort", 1, 1, 0, 0, 0);
    chk("abort.flushc", fc, 16'd1);
    tick(); tick(); tick();
    outs("abort_run", 1, 1, 0, 0, 0);

    // reset mid-drain leaves no residual stall
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
    tick();
    do_reset();
    outs("mid_drain_rst", 1, 1, 0, 0, 0);

    // saturation of the stall counter
    drive(v[0].i);
    for (int k = 0; k < 65535; k++) @(posedge clk);
    #1;
    chk("sat.ffff", sc, 16'hFFFF);
    for (int k = 0; k < 5; k++) @(posedge clk);
    #1;
    chk("sat.hold", sc, 16'hFFFF);
    drive('0);
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
    tick(); tick(); tick();
    chk("sat.halted", {15'd0, halted}, 16'd1);
    do_reset();
    chk("sat.rst_stall", sc, 16'd0);
    chk("sat.rst_flush", fc, 16'd0);
    outs("sat.rst_run", 1, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
